cache_meta_array: RTL and testbench
===================================

# cache_meta_array

Parametrised tag/valid/replacement metadata store for the set-associative caches, sitting beside each cache's data array and feeding the cache controller's hit/miss logic. It takes a lookup (set, tag), returns a registered hit, hit way and victim way one cycle later, and updates pseudo-LRU state on hits and fills. A flush sequencer invalidates the whole array one set per cycle, and reset clears the array in a single cycle.

## Interface
- `SETS`, 64: number of sets; power of two, minimum 2. `SIDX_W = $clog2(SETS)`.
- `WAYS`, 2: associativity; only 2 or 4 are legal. `WAY_W = $clog2(WAYS)`.
- `TAG_W`, 7: stored tag width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `lookup_valid` in 1: lookup request this cycle.
- `lookup_set` in SIDX_W: set index for the lookup.
- `lookup_tag` in TAG_W: tag to compare.
- `fill_en` in 1: write a tag into the array.
- `fill_set` in SIDX_W: set index for the fill.
- `fill_way` in WAY_W: way to write.
- `fill_tag` in TAG_W: tag to write.
- `flush_req` in 1: start a full invalidate; single-cycle pulse.
- `hit` out 1: registered; the previous-cycle lookup hit.
- `hit_way` out WAY_W: registered; the hitting way, 0 when `hit` = 0.
- `victim_way` out WAY_W: registered; replacement way for the looked-up set.
- `lookup_done` out 1: registered; `hit`, `hit_way` and `victim_way` are valid.
- `busy` out 1: flush in progress.
- `flush_done` out 1: one-cycle pulse when the flush completes.
- `parity_err` out 1: registered; see Configuration.

## Operation
- Storage per set: WAYS × {valid, tag} plus replacement state. WAYS=2 uses 1 bit; WAYS=4 uses 3 bits (b0, b1, b2).
- Lookup:
  - Compares `lookup_tag` against every valid way of `lookup_set`.
  - At most one way may match; multiple matches are a controller bug.
- Victim selection:
  - The lowest-index invalid way is chosen first.
  - If all ways are valid, the PLRU victim is chosen.
  - 2-way: victim = bit.
  - 4-way: if b0=0, victim = b1 ? 1 : 0; otherwise victim = b2 ? 3 : 2.
- PLRU update on access to way w (a hit or a fill), pointing the state away from w:
  - 2-way: bit = ~w.
  - 4-way, w0: b0=1, b1=1.
  - 4-way, w1: b0=1, b1=0.
  - 4-way, w2: b0=0, b2=1.
  - 4-way, w3: b0=0, b2=0.
- Fill: writes the tag, sets valid=1 and marks the way MRU. Fills overwrite regardless of the prior contents.
- Flush FSM has two states:
  - IDLE: `flush_req` → FLUSH, with counter = 0.
  - FLUSH: clears valid and PLRU state of set[counter] each cycle and increments the counter. At counter = SETS-1 it clears that set, pulses `flush_done` on the following cycle and returns to IDLE.
  - `busy` = 1 throughout FLUSH.
- While `busy`:
  - Lookups return `lookup_done` = 1 with `hit` = 0 and `victim_way` = 0.
  - Lookups do not update PLRU state.
  - Fills are dropped.
  - `flush_req` is ignored.
- Same-set lookup and fill in one cycle:
  - The lookup sees pre-fill contents (read-before-write).
  - The PLRU update from the fill wins over the update from the hit.
- Different-set lookup and fill: both take effect independently.
- Reset, including mid-flush:
  - All valid bits = 0, all PLRU state = 0, FSM → IDLE, counter = 0.
  - All outputs = 0.
  - Tags are not cleared.

## Timing
- Lookup at edge N → `lookup_done`/`hit`/`hit_way`/`victim_way` valid after edge N+1, for exactly one cycle. Outputs return to 0 when no lookup was presented.
- A hit updates PLRU state at edge N+1. A back-to-back lookup of the same set at N+1 observes the update.
- A fill written at edge N is visible to a lookup presented at N+1.
- Flush occupies SETS cycles with `busy` high. `flush_done` is asserted in the first cycle with `busy` = 0.
- Throughput: one lookup plus one fill per cycle.

## Configuration
- `CACHE_META_PARITY_EN` defined:
  - Each way stores an even-parity bit over {valid, tag}, written on fill and on flush clear.
  - A lookup that finds a parity mismatch in any way of the set asserts `parity_err` with the lookup result, and forces `hit` = 0 for that lookup.
  - Injection is handled by the bench via hierarchical force.
- Undefined: no parity storage, and `parity_err` is tied to 0.

## Test plan
- Reset, then lookup set 5 tag 0x12 → `hit`=0 and `victim_way`=0. All outputs are 0 during reset.
- WAYS=2: fill set 3 way0 tag 0x11; lookup set 3 tag 0x11 → `hit`=1, `hit_way`=0. A next lookup of set 3 with tag 0x22 → `hit`=0, `victim_way`=1 (way1 invalid).
- WAYS=4: fill ways 0–3 of set 7 with tags 0x40–0x43; lookup tag 0x40 → `hit`=1. A following miss lookup → `victim_way`=2 (b0=1, b2=0).
- Same-cycle fill of set 9 way1 tag 0x33 and lookup of set 9 tag 0x33 → `hit`=0. A repeated lookup next cycle → `hit`=1, `hit_way`=1.
- `flush_req` with SETS=64 → `busy` high for 64 cycles. A lookup during the flush → `hit`=0. A fill during the flush is dropped. `flush_done` pulses once. Afterwards, every previously filled tag misses.
- Assert `rst` at flush cycle 10 → next cycle `busy`=0 and all valid bits are 0. `flush_done` never pulses. A new `flush_req` then completes normally.

Source files
------------

// File: rtl/cache_meta_array.sv
// Tag/valid/pseudo-LRU metadata store with registered lookup, fill port and one-set-per-cycle flush.
// Optional CACHE_META_PARITY_EN adds an even-parity bit per way over {valid, tag}.
module cache_meta_array #(
  parameter  int SETS   = 64,
  parameter  int WAYS   = 2,
  parameter  int TAG_W  = 7,
  localparam int SIDX_W = $clog2(SETS),
  localparam int WAY_W  = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid,
  input  logic [SIDX_W-1:0] lookup_set,
  input  logic [TAG_W-1:0]  lookup_tag,
  input  logic              fill_en,
  input  logic [SIDX_W-1:0] fill_set,
  input  logic [WAY_W-1:0]  fill_way,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic              flush_req,
  output logic              hit,
  output logic [WAY_W-1:0]  hit_way,
  output logic [WAY_W-1:0]  victim_way,
  output logic              lookup_done,
  output logic              busy,
  output logic              flush_done,
  output logic              parity_err
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [SIDX_W-1:0]   cnt_q;
  logic                last_set;

  logic [WAYS-1:0]     valid_q [SETS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [2:0]          plru_q  [SETS];

  logic [WAYS-1:0]     match;
  logic                hit_c;
  logic                hit_eff;
  logic                perr_c;
  logic [WAY_W-1:0]    hw_c;
  logic [WAY_W-1:0]    vic_c;
  logic                lookup_ok;
  logic                fill_ok;

  function automatic logic [WAY_W-1:0] plru_victim(input logic [2:0] p);
    if (WAYS == 2) return WAY_W'(p[0]);
    if (!p[0])     return p[1] ? WAY_W'(1) : WAY_W'(0);
    return p[2] ? WAY_W'(3) : WAY_W'(2);
  endfunction

  // Point the tree away from the accessed way
  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [WAY_W-1:0] w);
    logic [2:0] n;
    int         wi;
    n  = p;
    wi = int'(w);
    if (WAYS == 2) begin
      n[0] = (wi == 0);
    end else begin
      case (wi)
        0:       begin n[0] = 1'b1; n[1] = 1'b1; end
        1:       begin n[0] = 1'b1; n[1] = 1'b0; end
        2:       begin n[0] = 1'b0; n[2] = 1'b1; end
        default: begin n[0] = 1'b0; n[2] = 1'b0; end
      endcase
    end
    return n;
  endfunction

  assign busy      = (state_q == FLUSH);
  assign last_set  = busy && (cnt_q == SIDX_W'(SETS - 1));
  assign lookup_ok = lookup_valid && !busy;
  assign fill_ok   = fill_en && !busy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_req) state_d = FLUSH;
      FLUSH:   if (last_set)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_META_PARITY_EN
  logic [WAYS-1:0] par_q [SETS];
`endif

  // Stage p0: tag compare and victim pick on the current array contents
  always_comb begin
    match  = '0;
    hw_c   = '0;
    vic_c  = plru_victim(plru_q[lookup_set]);
    perr_c = 1'b0;
    for (int w = 0; w < WAYS; w++)
      match[w] = valid_q[lookup_set][w] && (tag_q[lookup_set][w] == lookup_tag);
    for (int w = 0; w < WAYS; w++)
      if (match[w]) hw_c = WAY_W'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[lookup_set][w]) vic_c = WAY_W'(w);
`ifdef CACHE_META_PARITY_EN
    for (int w = 0; w < WAYS; w++)
      perr_c = perr_c | (par_q[lookup_set][w] != ^{valid_q[lookup_set][w], tag_q[lookup_set][w]});
`endif
  end

  assign hit_c   = |match;
  assign hit_eff = hit_c && !perr_c;

  // Stage p1: registered lookup result and flush control
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      flush_done  <= 1'b0;
      lookup_done <= 1'b0;
      hit         <= 1'b0;
      hit_way     <= '0;
      victim_way  <= '0;
      parity_err  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= busy ? cnt_q + SIDX_W'(1) : '0;
      flush_done  <= last_set;
      lookup_done <= lookup_valid;
      hit         <= lookup_ok && hit_eff;
      hit_way     <= (lookup_ok && hit_eff) ? hw_c : '0;
      victim_way  <= lookup_ok ? vic_c : '0;
      parity_err  <= lookup_ok && perr_c;
    end
  end

  // Fill PLRU update is issued last so it overrides a same-set hit update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
`ifdef CACHE_META_PARITY_EN
        for (int w = 0; w < WAYS; w++) par_q[s][w] <= ^tag_q[s][w];
`endif
      end
    end else begin
      if (lookup_ok && hit_eff)
        plru_q[lookup_set] <= plru_touch(plru_q[lookup_set], hw_c);
      if (fill_ok) begin
        valid_q[fill_set][fill_way] <= 1'b1;
        plru_q[fill_set]            <= plru_touch(plru_q[fill_set], fill_way);
`ifdef CACHE_META_PARITY_EN
        par_q[fill_set][fill_way]   <= ^{1'b1, fill_tag};
`endif
      end
      if (busy) begin
        valid_q[cnt_q] <= '0;
        plru_q[cnt_q]  <= '0;
`ifdef CACHE_META_PARITY_EN
        for (int w = 0; w < WAYS; w++) par_q[cnt_q][w] <= ^tag_q[cnt_q][w];
`endif
      end
    end
  end

  // Tags are never reset; only valid bits gate their use
  always_ff @(posedge clk) begin
    if (fill_ok) tag_q[fill_set][fill_way] <= fill_tag;
  end

endmodule

// File: tb/tb_cache_meta_array.sv
// Scoreboard bench for cache_meta_array: one 2-way and one 4-way instance driven by directed vectors.
module tb_cache_meta_array;

  typedef struct {
    logic       h;
    logic [1:0] hw;
    logic [1:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t q2[$];
  exp_t q4[$];

  // 4-way instance
  logic       lv4 = 0, fe4 = 0, fr4 = 0;
  logic [5:0] ls4 = 0, fs4 = 0;
  logic [6:0] lt4 = 0, ft4 = 0;
  logic [1:0] fw4 = 0;
  logic       hit4, done4, busy4, fdone4, perr4;
  logic [1:0] hw4, vic4;

  // 2-way instance
  logic       lv2 = 0, fe2 = 0, fr2 = 0;
  logic [5:0] ls2 = 0, fs2 = 0;
  logic [6:0] lt2 = 0, ft2 = 0;
  logic [0:0] fw2 = 0;
  logic       hit2, done2, busy2, fdone2, perr2;
  logic [0:0] hw2, vic2;

  cache_meta_array #(.SETS(64), .WAYS(4), .TAG_W(7)) dut4 (
    .clk(clk), .rst(rst),
    .lookup_valid(lv4), .lookup_set(ls4), .lookup_tag(lt4),
    .fill_en(fe4), .fill_set(fs4), .fill_way(fw4), .fill_tag(ft4),
    .flush_req(fr4),
    .hit(hit4), .hit_way(hw4), .victim_way(vic4), .lookup_done(done4),
    .busy(busy4), .flush_done(fdone4), .parity_err(perr4)
  );

  cache_meta_array #(.SETS(64), .WAYS(2), .TAG_W(7)) dut2 (
    .clk(clk), .rst(rst),
    .lookup_valid(lv2), .lookup_set(ls2), .lookup_tag(lt2),
    .fill_en(fe2), .fill_set(fs2), .fill_way(fw2), .fill_tag(ft2),
    .flush_req(fr2),
    .hit(hit2), .hit_way(hw2), .victim_way(vic2), .lookup_done(done2),
    .busy(busy2), .flush_done(fdone2), .parity_err(perr2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    lv4 = 0; fe4 = 0; fr4 = 0;
    lv2 = 0; fe2 = 0; fr2 = 0;
  endtask

  task automatic look4(input int s, input int t, input int h, input int hw, input int v);
    exp_t e;
    lv4 = 1; ls4 = 6'(s); lt4 = 7'(t);
    e.h = 1'(h); e.hw = 2'(hw); e.v = 2'(v);
    q4.push_back(e);
  endtask

  task automatic look2(input int s, input int t, input int h, input int hw, input int v);
    exp_t e;
    lv2 = 1; ls2 = 6'(s); lt2 = 7'(t);
    e.h = 1'(h); e.hw = 2'(hw); e.v = 2'(v);
    q2.push_back(e);
  endtask

  task automatic fill4(input int s, input int w, input int t);
    fe4 = 1; fs4 = 6'(s); fw4 = 2'(w); ft4 = 7'(t);
  endtask

  task automatic fill2(input int s, input int w, input int t);
    fe2 = 1; fs2 = 6'(s); fw2 = 1'(w); ft2 = 7'(t);
  endtask

  // Monitors: pop one expectation per presented lookup result
  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) chk("lookup4_unexpected", 1, 0);
      else begin
        exp_t e;
        e = q4.pop_front();
        chk("lookup4_hit", int'(hit4), int'(e.h));
        chk("lookup4_hit_way", int'(hw4), int'(e.hw));
        chk("lookup4_victim", int'(vic4), int'(e.v));
      end
    end
    if (done2) begin
      if (q2.size() == 0) chk("lookup2_unexpected", 1, 0);
      else begin
        exp_t e;
        e = q2.pop_front();
        chk("lookup2_hit", int'(hit2), int'(e.h));
        chk("lookup2_hit_way", int'(hw2), int'(e.hw[0]));
        chk("lookup2_victim", int'(vic2), int'(e.v[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int pulses;

    // Reset: lookups driven during reset must not produce results
    rst = 1;
    lv4 = 1; ls4 = 6'd5; lt4 = 7'h12;
    lv2 = 1; ls2 = 6'd5; lt2 = 7'h12;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_outputs4", int'({hit4, hw4, vic4, done4, busy4, fdone4, perr4}), 0);
    chk("rst_outputs2", int'({hit2, hw2, vic2, done2, busy2, fdone2, perr2}), 0);
    step();
    chk("rst_done4", int'(done4), 0);
    rst = 0;

    look4(5, 'h12, 0, 0, 0);
    look2(5, 'h12, 0, 0, 0);
    step();

    // 2-way: fill, hit, invalid-way victim, then PLRU tracking
    fill2(3, 0, 'h11); step();
    look2(3, 'h11, 1, 0, 1); step();
    look2(3, 'h22, 0, 0, 1); step();
    fill2(3, 1, 'h22); step();
    look2(3, 'h55, 0, 0, 0); step();
    look2(3, 'h22, 1, 1, 0); step();
    look2(3, 'h11, 1, 0, 0); step();
    look2(3, 'h77, 0, 0, 1); step();

    // 4-way: fill set 7 and walk the PLRU tree
    fill4(7, 0, 'h40); step();
    look4(7, 'h99, 0, 0, 1); step();
    fill4(7, 1, 'h41); step();
    fill4(7, 2, 'h42); step();
    fill4(7, 3, 'h43); step();
    look4(7, 'h40, 1, 0, 0); step();
    look4(7, 'h99, 0, 0, 2); step();
    look4(7, 'h43, 1, 3, 2); step();
    look4(7, 'h98, 0, 0, 1); step();

    // Same-cycle same-set: lookup sees pre-fill contents
    fill4(9, 1, 'h33); look4(9, 'h33, 0, 0, 0); step();
    look4(9, 'h33, 1, 1, 0); step();

    // Same-cycle hit on way0 and fill of way2: fill's PLRU update wins
    look4(7, 'h40, 1, 0, 1); fill4(7, 2, 'h52); step();
    look4(7, 'h97, 0, 0, 1); step();
    look4(7, 'h52, 1, 2, 1); step();

    // Different-set lookup and fill in one cycle
    look4(7, 'h40, 1, 0, 1); fill4(10, 0, 'h66); step();
    look4(10, 'h66, 1, 0, 1); step();

    // Full flush with lookup, fill and extra flush_req while busy
    fr4 = 1; step();
    n = 0;
    while (busy4 && n < 200) begin
      if (n == 5) begin look4(7, 'h40, 0, 0, 0); fill4(11, 0, 'h77); end
      if (n == 20) fr4 = 1;
      n++;
      step();
    end
    chk("flush_busy_cycles", n, 64);
    chk("flush_done_first_idle", int'(fdone4), 1);
    pulses = 0;
    repeat (4) begin step(); pulses += int'(fdone4); end
    chk("flush_done_single_pulse", pulses, 0);
    look4(7, 'h40, 0, 0, 0); step();
    look4(9, 'h33, 0, 0, 0); step();
    look4(10, 'h66, 0, 0, 0); step();
    look4(11, 'h77, 0, 0, 0); step();

    // Reset in the middle of a flush
    fill4(20, 0, 'h21); step();
    fr4 = 1; step();
    chk("flush2_busy", int'(busy4), 1);
    repeat (10) step();
    rst = 1; step(); rst = 0;
    chk("midflush_rst_busy", int'(busy4), 0);
    pulses = 0;
    repeat (3) begin pulses += int'(fdone4); step(); end
    chk("midflush_no_done", pulses, 0);
    look4(20, 'h21, 0, 0, 0); step();

    // Fresh flush after the aborted one
    fr4 = 1; step();
    n = 0;
    while (busy4 && n < 200) begin n++; step(); end
    chk("flush3_busy_cycles", n, 64);
    chk("flush3_done", int'(fdone4), 1);

    repeat (3) step();
    chk("queue4_drained", q4.size(), 0);
    chk("queue2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
